envelope_sequencer: RTL and testbench

Parametrised piecewise-linear envelope generator, the successor to the fixed 8-stage stepped envelope inside `oscillator`. It adds several things the old envelope lacks:
- configurable stage count and widths;
- linear ramps between stage gains;
- a gate-controlled sustain hold and release;
- click-free retrigger;
- an optional loop mode.

It sits between the wavegen command decoder and the oscillator amplitude multiplier. It advances once per `sample_tick` and produces one gain value per sample.

---
 rtl/envelope_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_envelope_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/envelope_sequencer.sv
// Piecewise-linear envelope generator: linear ramps between per-stage gains, gate-held sustain,
// click-free retrigger and optional looping. The per-sample step comes from a serial divider.
module envelope_sequencer #(
    parameter int unsigned NUM_STAGES    = 8,
    parameter int unsigned GAIN_WIDTH    = 16,
    parameter int unsigned DUR_WIDTH     = 16,
    parameter int unsigned FRAC          = 16,
    parameter int unsigned SUSTAIN_STAGE = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             sample_tick,
    input  logic                             gate,
    input  logic                             retrigger,
    input  logic                             loop_en,
    input  logic [NUM_STAGES*GAIN_WIDTH-1:0] stage_gain,
    input  logic [NUM_STAGES*DUR_WIDTH-1:0]  stage_dur,
    output logic [GAIN_WIDTH-1:0]            gain,
    output logic [$clog2(NUM_STAGES)-1:0]    stage,
    output logic                             active,
    output logic                             busy
);

    localparam int unsigned AccW    = GAIN_WIDTH + FRAC;
    localparam int unsigned StW     = $clog2(NUM_STAGES);
    localparam int unsigned DivCntW = $clog2(AccW);

    localparam logic [StW-1:0]     SusStage  = StW'(SUSTAIN_STAGE);
    localparam logic [StW-1:0]     RelStage  = StW'(SUSTAIN_STAGE + 1);
    localparam logic [StW-1:0]     LastStage = StW'(NUM_STAGES - 1);
    localparam logic [DivCntW-1:0] DivLast   = DivCntW'(AccW - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StRun, StSustain} state_e;

    state_e                state_q, state_d;
    logic [StW-1:0]        stage_q, stage_d;
    logic [AccW-1:0]       acc_q, acc_d;
    logic [AccW-1:0]       quot_q, quot_d;  // dividend during SETUP, step size during RUN
    logic [DUR_WIDTH-1:0]  rem_q, rem_d;
    logic [DivCntW-1:0]    div_cnt_q, div_cnt_d;
    logic [DUR_WIDTH-1:0]  dur_q, dur_d;
    logic [DUR_WIDTH-1:0]  cnt_q, cnt_d;
    logic [GAIN_WIDTH-1:0] tgt_q, tgt_d;
    logic                  up_q, up_d;
    logic                  tick_pend_q, tick_pend_d;
    logic                  gate_q, gate_prev_q, retrig_q;

    logic start_ev, release_ev, tick_ev;

    assign start_ev   = (gate_q & ~gate_prev_q) | (retrig_q & gate_q);
    assign release_ev = ~gate_q & gate_prev_q & (state_q != StIdle) & (stage_q <= SusStage);
    assign tick_ev    = sample_tick | tick_pend_q;

    // Restoring division, one quotient bit per cycle.
    logic [DUR_WIDTH:0]   div_shift;
    logic                 div_ge;
    logic [DUR_WIDTH-1:0] div_rem;

    assign div_shift = {rem_q, quot_q[AccW-1]};
    assign div_ge    = div_shift >= {1'b0, dur_q};
    assign div_rem   = div_ge ? DUR_WIDTH'(div_shift - {1'b0, dur_q}) : div_shift[DUR_WIDTH-1:0];

    logic [AccW:0]   tgt_full, acc_up, down_lim;
    logic [AccW-1:0] acc_step;

    assign tgt_full = {1'b0, tgt_q, {FRAC{1'b0}}};
    assign acc_up   = {1'b0, acc_q} + {1'b0, quot_q};
    assign down_lim = tgt_full + {1'b0, quot_q};

    // A step that would cross the target lands on it instead.
    always_comb begin
        if (up_q) begin
            acc_step = (acc_up >= tgt_full) ? tgt_full[AccW-1:0] : acc_up[AccW-1:0];
        end else begin
            acc_step = ({1'b0, acc_q} <= down_lim) ? tgt_full[AccW-1:0] : acc_q - quot_q;
        end
    end

    logic                  load_setup;
    logic [StW-1:0]        setup_stage;
    logic [GAIN_WIDTH-1:0] new_tgt, cur_gain, new_mag;
    logic [DUR_WIDTH-1:0]  new_dur, cnt_inc;

    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        acc_d       = acc_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        div_cnt_d   = div_cnt_q;
        dur_d       = dur_q;
        cnt_d       = cnt_q;
        tgt_d       = tgt_q;
        up_d        = up_q;
        tick_pend_d = tick_pend_q;
        load_setup  = 1'b0;
        setup_stage = stage_q;
        cnt_inc     = cnt_q + 1'b1;
        new_tgt     = '0;
        new_dur     = '0;
        cur_gain    = '0;
        new_mag     = '0;

        if (start_ev) begin
            load_setup  = 1'b1;
            setup_stage = '0;
        end else if (release_ev) begin
            load_setup  = 1'b1;
            setup_stage = RelStage;
        end else begin
            unique case (state_q)
                StSetup: begin
                    quot_d    = {quot_q[AccW-2:0], div_ge};
                    rem_d     = div_rem;
                    div_cnt_d = div_cnt_q + 1'b1;
                    if (sample_tick) begin
                        tick_pend_d = 1'b1;
                    end
                    if (div_cnt_q == DivLast) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (tick_ev) begin
                        tick_pend_d = 1'b0;
                        cnt_d       = cnt_inc;
                        if (cnt_inc == dur_q) begin
                            acc_d = tgt_full[AccW-1:0];
                            if (stage_q == SusStage && gate_q) begin
                                if (loop_en) begin
                                    load_setup  = 1'b1;
                                    setup_stage = '0;
                                end else begin
                                    state_d = StSustain;
                                end
                            end else if (stage_q == LastStage) begin
                                state_d = StIdle;
                            end else begin
                                load_setup  = 1'b1;
                                setup_stage = stage_q + 1'b1;
                            end
                        end else begin
                            acc_d = acc_step;
                        end
                    end
                end
                default: ;
            endcase
        end

        // Stage parameters are captured here; the ramp starts from the current level.
        if (load_setup) begin
            new_tgt     = stage_gain[int'(setup_stage)*GAIN_WIDTH +: GAIN_WIDTH];
            new_dur     = stage_dur[int'(setup_stage)*DUR_WIDTH +: DUR_WIDTH];
            cur_gain    = acc_d[AccW-1:FRAC];
            state_d     = StSetup;
            stage_d     = setup_stage;
            tgt_d       = new_tgt;
            dur_d       = (new_dur == '0) ? DUR_WIDTH'(1) : new_dur;
            up_d        = new_tgt >= cur_gain;
            new_mag     = up_d ? new_tgt - cur_gain : cur_gain - new_tgt;
            quot_d      = {new_mag, {FRAC{1'b0}}};
            rem_d       = '0;
            div_cnt_d   = '0;
            cnt_d       = '0;
            tick_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            stage_q     <= '0;
            acc_q       <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            div_cnt_q   <= '0;
            dur_q       <= '0;
            cnt_q       <= '0;
            tgt_q       <= '0;
            up_q        <= 1'b0;
            tick_pend_q <= 1'b0;
            gate_q      <= 1'b0;
            gate_prev_q <= 1'b0;
            retrig_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            acc_q       <= acc_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            div_cnt_q   <= div_cnt_d;
            dur_q       <= dur_d;
            cnt_q       <= cnt_d;
            tgt_q       <= tgt_d;
            up_q        <= up_d;
            tick_pend_q <= tick_pend_d;
            gate_q      <= gate;
            gate_prev_q <= gate_q;
            retrig_q    <= retrigger;
        end
    end

    assign gain   = acc_q[AccW-1:FRAC];
    assign stage  = stage_q;
    assign active = state_q != StIdle;
    assign busy   = state_q == StSetup;

endmodule

// File: tb/tb_envelope_sequencer.sv
// Bench for envelope_sequencer: stimulus queues hand-computed expected outputs, and a monitor
// compares them whenever a tick result or an explicit probe is presented.
module tb_envelope_sequencer;

    localparam int NS = 8;
    localparam int GW = 16;
    localparam int DW = 16;

    logic             clk         = 1'b0;
    logic             rst         = 1'b1;
    logic             sample_tick = 1'b0;
    logic             gate        = 1'b0;
    logic             retrigger   = 1'b0;
    logic             loop_en     = 1'b0;
    logic [NS*GW-1:0] stage_gain  = '0;
    logic [NS*DW-1:0] stage_dur   = '0;
    logic [GW-1:0]    gain;
    logic [2:0]       stage;
    logic             active;
    logic             busy;

    always #5 clk = ~clk;

    envelope_sequencer #(
        .NUM_STAGES   (NS),
        .GAIN_WIDTH   (GW),
        .DUR_WIDTH    (DW),
        .FRAC         (16),
        .SUSTAIN_STAGE(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_tick(sample_tick),
        .gate       (gate),
        .retrigger  (retrigger),
        .loop_en    (loop_en),
        .stage_gain (stage_gain),
        .stage_dur  (stage_dur),
        .gain       (gain),
        .stage      (stage),
        .active     (active),
        .busy       (busy)
    );

    typedef struct {
        string name;
        int    g;
        int    st;
        int    act;
        int    bsy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic tick_seen  = 1'b0;
    logic probe_req  = 1'b0;
    logic probe_seen = 1'b0;

    task automatic cmp(input string name, input string field, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s %s: got %0d, want %0d", name, field, act, req);
        end
    endtask

    always @(posedge clk) begin
        tick_seen  <= sample_tick;
        probe_seen <= probe_req;
    end

    // Monitor: one queued expectation per presented output.
    always @(negedge clk) begin
        exp_t e;
        if (tick_seen || probe_seen) begin
            if (exp_q.size() == 0) begin
                cmp("monitor", "queued_expectations", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                cmp(e.name, "gain", int'(gain), e.g);
                cmp(e.name, "stage", int'(stage), e.st);
                cmp(e.name, "active", int'(active), e.act);
                cmp(e.name, "busy", int'(busy), e.bsy);
            end
        end
    end

    task automatic push_exp(input string n, input int g, input int st, input int act,
                            input int bsy);
        exp_t e;
        e.name = n;
        e.g    = g;
        e.st   = st;
        e.act  = act;
        e.bsy  = bsy;
        exp_q.push_back(e);
    endtask

    task automatic tick_chk(input string n, input int g, input int st, input int act,
                            input int bsy);
        push_exp(n, g, st, act, bsy);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (38) @(negedge clk);
    endtask

    task automatic probe(input string n, input int g, input int st, input int act, input int bsy);
        push_exp(n, g, st, act, bsy);
        @(negedge clk);
        probe_req = 1'b1;
        @(negedge clk);
        probe_req = 1'b0;
    endtask

    task automatic wait_setup(input string n);
        int k;
        int len;
        k = 0;
        while (busy !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        len = 0;
        while (busy === 1'b1 && len < 100) begin
            @(negedge clk);
            len++;
        end
        cmp(n, "busy_cycles", len, 32);
    endtask

    task automatic ramp(input string n, input int start, input int step, input int ticks,
                        input int st, input int fin, input int nst, input int nact,
                        input int nbsy);
        for (int k = 1; k < ticks; k++) begin
            tick_chk($sformatf("%s_t%0d", n, k), start + step * k, st, 1, 0);
        end
        tick_chk($sformatf("%s_t%0d", n, ticks), fin, nst, nact, nbsy);
    endtask

    task automatic set_stage(input int i, input int g, input int d);
        stage_gain[i*GW +: GW] = GW'(g);
        stage_dur[i*DW +: DW]  = DW'(d);
    endtask

    task automatic cfg_a();
        set_stage(0, 1000, 10);
        set_stage(1, 500, 5);
        set_stage(2, 800, 4);
        set_stage(3, 600, 8);
        set_stage(4, 0, 6);
        set_stage(5, 0, 1);
        set_stage(6, 0, 1);
        set_stage(7, 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        cfg_a();
        repeat (2) @(negedge clk);
        probe("reset", 0, 0, 0, 0);
        rst = 1'b0;

        // Ramps through stages 0..3, sustain, release, then idle.
        gate = 1'b1;
        wait_setup("a_start");
        ramp("a_s0", 0, 100, 10, 0, 1000, 1, 1, 1);
        ramp("a_s1", 1000, -100, 5, 1, 500, 2, 1, 1);
        ramp("a_s2", 500, 75, 4, 2, 800, 3, 1, 1);
        ramp("a_s3", 800, -25, 8, 3, 600, 3, 1, 0);
        for (int i = 1; i <= 50; i++) begin
            tick_chk($sformatf("a_sus%0d", i), 600, 3, 1, 0);
        end
        gate = 1'b0;
        wait_setup("a_release");
        probe("a_rel_start", 600, 4, 1, 0);
        ramp("a_s4", 600, -100, 6, 4, 0, 5, 1, 1);
        tick_chk("a_s5", 0, 6, 1, 1);
        tick_chk("a_s6", 0, 7, 1, 1);
        tick_chk("a_s7", 0, 7, 0, 0);
        probe("a_idle", 0, 7, 0, 0);

        // Retrigger at 450, a tick inside SETUP, then a zero-duration stage.
        do_reset();
        set_stage(0, 1000, 20);
        gate = 1'b1;
        wait_setup("b_start");
        for (int i = 1; i <= 9; i++) begin
            tick_chk($sformatf("b_s0_t%0d", i), 50 * i, 0, 1, 0);
        end
        set_stage(0, 1000, 10);
        @(negedge clk);
        retrigger = 1'b1;
        @(negedge clk);
        retrigger = 1'b0;
        k = 0;
        while (busy !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        probe("b_retrig_hold", 450, 0, 1, 1);
        tick_chk("b_pend_tick", 450, 0, 1, 1);
        probe("b_pend_applied", 505, 0, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            tick_chk($sformatf("b_re_t%0d", i), 505 + 55 * i, 0, 1, 0);
        end
        set_stage(1, 500, 0);
        tick_chk("b_s0_end", 1000, 1, 1, 1);
        tick_chk("b_dur0", 500, 2, 1, 1);

        // Down-ramp by a single LSB over 7 ticks.
        gate = 1'b0;
        do_reset();
        cfg_a();
        set_stage(1, 999, 7);
        gate = 1'b1;
        wait_setup("c_start");
        ramp("c_s0", 0, 100, 10, 0, 1000, 1, 1, 1);
        ramp("c_s1", 999, 0, 7, 1, 999, 2, 1, 1);

        // Loop mode, then a reset in the middle of RUN.
        gate = 1'b0;
        do_reset();
        cfg_a();
        loop_en = 1'b1;
        gate = 1'b1;
        wait_setup("d_start");
        ramp("d_s0", 0, 100, 10, 0, 1000, 1, 1, 1);
        ramp("d_s1", 1000, -100, 5, 1, 500, 2, 1, 1);
        ramp("d_s2", 500, 75, 4, 2, 800, 3, 1, 1);
        ramp("d_s3", 800, -25, 8, 3, 600, 0, 1, 1);
        ramp("d_loop_s0", 600, 40, 10, 0, 1000, 1, 1, 1);
        tick_chk("d_loop_s1", 900, 1, 1, 0);
        push_exp("d_reset", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        probe_req = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        probe_req = 1'b0;
        gate = 1'b0;
        loop_en = 1'b0;
        repeat (5) @(negedge clk);

        cmp("end", "pending_expectations", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
